// File: rtl/fp32_pkg.sv
// Shared fp32 field widths, special encodings and accumulator FSM states
// for the 2x2 block accumulator datapath.
package fp32_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;
  localparam int FP32_EMAX  = 2 * FP32_BIAS + 1;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    ADD   = 2'd2
  } acc_state_e;

endpackage

// File: rtl/fp32_adder.sv
// fp32 adder (RNE, flush-to-zero, canonical NaN). The sum is captured on
// launch and ready pulses ADD_LATENCY cycles later.
module fp32_adder
  import fp32_pkg::*;
#(
  parameter int ADD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        launch,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        ready
);

  function automatic logic [7:0] expf(input logic [31:0] v);
    return v[FP32_MAN_W +: FP32_EXP_W];
  endfunction

  logic [31:0]       fa, fb, x, y, sum_c;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [7:0]        d;
  logic [26:0]       mx, my, my_al, dif, norm;
  logic [53:0]       sh;
  logic [27:0]       tot;
  logic [4:0]        lz;
  logic signed [9:0] e_r;
  logic [30:0]       rnd_r;
  logic              rnd;

  always_comb begin
    fa     = (expf(a) == 8'd0) ? FP32_ZERO : a;
    fb     = (expf(b) == 8'd0) ? FP32_ZERO : b;
    a_nan  = (&expf(fa)) &&  (|fa[22:0]);
    b_nan  = (&expf(fb)) &&  (|fb[22:0]);
    a_inf  = (&expf(fa)) && ~(|fa[22:0]);
    b_inf  = (&expf(fb)) && ~(|fb[22:0]);
    a_zero = (fa[30:0] == 31'd0);
    b_zero = (fb[30:0] == 31'd0);

    // x carries the larger magnitude, so the subtract path never goes negative
    if (fb[30:0] > fa[30:0]) begin
      x = fb;
      y = fa;
    end else begin
      x = fa;
      y = fb;
    end
    d  = expf(x) - expf(y);
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    sh = {my, 27'd0} >> d;
    my_al = (d >= 8'd27) ? 27'd1 : {sh[53:28], sh[27] | (|sh[26:0])};

    if (x[31] == y[31]) tot = {1'b0, mx} + {1'b0, my_al};
    else                tot = {1'b0, mx - my_al};
    dif = tot[26:0];

    lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (dif[i]) lz = 5'(26 - i);

    if (tot[27]) begin
      norm = {tot[27:2], tot[1] | tot[0]};
      e_r  = $signed({2'b00, expf(x)}) + 10'sd1;
    end else begin
      norm = dif << lz;
      e_r  = $signed({2'b00, expf(x)}) - $signed({5'b00000, lz});
    end

    // Rounding carry ripples into the exponent field, so 254 -> 255 yields inf
    rnd   = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd_r = {e_r[7:0], norm[25:3]} + {30'd0, rnd};

    sum_c = {x[31], rnd_r};
    if (a_nan || b_nan || (a_inf && b_inf && (fa[31] != fb[31])))
      sum_c = FP32_QNAN;
    else if (a_inf)            sum_c = fa;
    else if (b_inf)            sum_c = fb;
    else if (a_zero)           sum_c = fb;
    else if (b_zero)           sum_c = fa;
    else if (!norm[26])        sum_c = FP32_ZERO;
    else if (int'(e_r) >= FP32_EMAX) sum_c = {x[31], FP32_PINF[30:0]};
    else if (int'(e_r) <= 0)   sum_c = FP32_ZERO;
  end

  logic [ADD_LATENCY:1] vld_q;
  logic [ADD_LATENCY:0] vld_pipe;
  logic [31:0]          res_q;

  assign vld_pipe = {vld_q, launch};

  // A fresh launch flushes any older token still in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      res_q <= FP32_ZERO;
    end else begin
      vld_q <= launch ? ADD_LATENCY'(1) : vld_pipe[ADD_LATENCY-1:0];
      if (launch) res_q <= sum_c;
    end
  end

  assign result = res_q;
  assign ready  = vld_pipe[ADD_LATENCY];

endmodule

// File: rtl/fp32_block_accumulator.sv
// 2x2 fp32 block accumulator: acc_ij <= acc_ij + i_aij per start, four lockstep adders.
// Optional ACC_SYNC_CLEAR_EN adds a synchronous active-high clear port.
module fp32_block_accumulator
  import fp32_pkg::*;
#(
  parameter int ADD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef ACC_SYNC_CLEAR_EN
  input  logic        clear,
`endif
  input  logic [31:0] i_a11,
  input  logic [31:0] i_a12,
  input  logic [31:0] i_a21,
  input  logic [31:0] i_a22,
  output logic [31:0] o_a11,
  output logic [31:0] o_a12,
  output logic [31:0] o_a21,
  output logic [31:0] o_a22,
  output logic        done
);

  acc_state_e                        state_q;
  logic [NUM_LANES-1:0][31:0]        acc_q, op_q, sum;
  logic [NUM_LANES-1:0]              rdy;
  logic                              launch_q, done_q, add_rdy;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    fp32_adder #(.ADD_LATENCY(ADD_LATENCY)) u_add (
      .clk    (clk),
      .reset  (reset),
      .launch (launch_q),
      .a      (acc_q[n]),
      .b      (op_q[n]),
      .result (sum[n]),
      .ready  (rdy[n])
    );
  end

  // Ignore ready while launching so a token orphaned by clear cannot retire early
  assign add_rdy = (&rdy) && !launch_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      op_q     <= '0;
      launch_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
`ifdef ACC_SYNC_CLEAR_EN
      if (clear) begin
        state_q  <= IDLE;
        acc_q    <= '0;
        op_q     <= '0;
        launch_q <= 1'b0;
        done_q   <= 1'b0;
      end else
`endif
      begin
        launch_q <= 1'b0;
        done_q   <= 1'b0;
        case (state_q)
          IDLE: if (start) begin
            op_q    <= {i_a22, i_a21, i_a12, i_a11};
            state_q <= SETUP;
          end
          SETUP: begin
            launch_q <= 1'b1;
            state_q  <= ADD;
          end
          ADD: if (add_rdy) begin
            acc_q   <= sum;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_a11 = acc_q[0];
  assign o_a12 = acc_q[1];
  assign o_a21 = acc_q[2];
  assign o_a22 = acc_q[3];
  assign done  = done_q;

endmodule

// File: tb/tb_fp32_block_accumulator.sv
// Randomized + directed scoreboard bench for fp32_block_accumulator against
// an exact-arithmetic fp32 addition model.
module tb_fp32_block_accumulator;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] i_a11, i_a12, i_a21, i_a22;
  logic [31:0] o_a11, o_a12, o_a21, o_a22;
  logic        done;
`ifdef ACC_SYNC_CLEAR_EN
  logic        clear = 1'b0;
`endif

  int vectors = 0, miscompares = 0, cyc = 0;

  typedef struct {
    logic [3:0][31:0] v;
    int               cyc;
  } exp_t;
  exp_t sbq[$];

  logic [3:0][31:0] acc_m, last, outs;
  logic [31:0] specials [8] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                32'h7FC0_0001, 32'h0001_2345, 32'h7F7F_FFFF, 32'h0080_0000};

  fp32_block_accumulator #(.ADD_LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef ACC_SYNC_CLEAR_EN
    .clear (clear),
`endif
    .i_a11 (i_a11),
    .i_a12 (i_a12),
    .i_a21 (i_a21),
    .i_a22 (i_a22),
    .o_a11 (o_a11),
    .o_a12 (o_a12),
    .o_a21 (o_a21),
    .o_a22 (o_a22),
    .done  (done)
  );

  assign outs = {o_a22, o_a21, o_a12, o_a11};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact sum of the two operands on a wide integer grid, then a single RNE rounding
  function automatic logic [31:0] fadd_ref(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0]  a, b;
    logic [299:0] A, B, M, q, rem, half;
    int           ea, eb, emin, p, sh, E;
    logic         sg;
    a = (a_in[30:23] == 8'd0) ? 32'd0 : a_in;
    b = (b_in[30:23] == 8'd0) ? 32'd0 : b_in;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return 32'h7FC0_0000;
    if (a[30:0] == 31'h7F80_0000 && b[30:0] == 31'h7F80_0000)
      return (a[31] == b[31]) ? a : 32'h7FC0_0000;
    if (a[30:0] == 31'h7F80_0000) return a;
    if (b[30:0] == 31'h7F80_0000) return b;
    if (a[30:0] == 0) return b;
    if (b[30:0] == 0) return a;
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    emin = (ea < eb) ? ea : eb;
    A = 300'({1'b1, a[22:0]}) << (ea - emin);
    B = 300'({1'b1, b[22:0]}) << (eb - emin);
    if (a[31] == b[31])  begin M = A + B; sg = a[31]; end
    else if (A >= B)     begin M = A - B; sg = a[31]; end
    else                 begin M = B - A; sg = b[31]; end
    if (M == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 300; i++) if (M[i]) p = i;
    if (p > 23) begin
      sh   = p - 23;
      q    = M >> sh;
      rem  = M - (q << sh);
      half = 300'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q[24]) begin q = q >> 1; sh++; end
    end else begin
      sh = p - 23;
      q  = M << (23 - p);
    end
    E = emin + sh;
    if (E >= 255) return {sg, 8'hFF, 23'd0};
    if (E <= 0)   return 32'd0;
    return {sg, 8'(E), q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp(input logic [31:0] cur);
    case ($urandom_range(0, 7))
      0:       return $urandom;
      1:       return specials[$urandom_range(0, 7)];
      2:       return cur ^ 32'h8000_0000;
      3:       return {1'($urandom), cur[30:23] - 8'd24, 23'($urandom_range(0, 1))};
      default: return {1'($urandom), 8'($urandom_range(118, 136)), 23'($urandom)};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: sampled 1ns after each rising edge
  initial begin
    exp_t e;
    last = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        for (int j = 0; j < 4; j++) chk("reset_out", outs[j], 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        last = '0;
      end else if (done) begin
        if (sbq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          for (int j = 0; j < 4; j++) chk($sformatf("lane%0d", j), outs[j], e.v[j]);
          last = e.v;
        end
      end else begin
        for (int j = 0; j < 4; j++) chk("hold", outs[j], last[j]);
      end
    end
  end

  task automatic drive(input logic [3:0][31:0] v);
    exp_t e;
    {i_a22, i_a21, i_a12, i_a11} = v;
    start = 1'b1;
    for (int j = 0; j < 4; j++) acc_m[j] = fadd_ref(acc_m[j], v[j]);
    e.v   = acc_m;
    e.cyc = cyc + 3 + L;
    sbq.push_back(e);
  endtask

  task automatic scramble;
    i_a11 = $urandom; i_a12 = $urandom; i_a21 = $urandom; i_a22 = $urandom;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (sbq.size() != 0 && n < 3 * L + 30) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic step(input logic [3:0][31:0] v);
    @(negedge clk);
    drive(v);
    @(negedge clk);
    start = 1'b0;
    scramble();
    wait_idle();
  endtask

  // start held through the done cycle: resampled immediately
  task automatic step2(input logic [3:0][31:0] v);
    @(negedge clk);
    drive(v);
    wait_idle();
    drive(v);
    @(negedge clk);
    start = 1'b0;
    scramble();
    wait_idle();
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    acc_m = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0][31:0] v, dir1;
    dir1  = {32'h4158A3D7, 32'h3EE66666, 32'h42EE999A, 32'h41F0F5C3};
    acc_m = '0;
    reset = 1'b0;
    start = 1'b1;
    {i_a22, i_a21, i_a12, i_a11} = dir1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);

    step2(dir1);

    do_reset(); step({4{32'h3F800000}}); step({4{32'hBF800000}});
    do_reset(); step({4{32'h7F800000}}); step({4{32'hFF800000}});
    do_reset(); step({4{32'h3F800000}}); step({4{32'h33800000}});
    do_reset(); step({4{32'h3F800000}}); step({4{32'h33800001}});

    // Reset while the adders are busy: no done, accumulators restart from zero
    do_reset();
    @(negedge clk);
    drive(dir1);
    @(negedge clk);
    start = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    acc_m = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    step(dir1);

    for (int t = 0; t < 60; t++) begin
      if (t % 12 == 11) do_reset();
      for (int j = 0; j < 4; j++) v[j] = rnd_fp(acc_m[j]);
      if ($urandom_range(0, 3) == 0) step2(v);
      else                           step(v);
    end

    repeat (5) @(negedge clk);
    chk("drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
